btb_update_queue: RTL and testbench
===================================

Name: btb_update_queue

Overview:
- Buffers resolved control-flow updates from the branch-resolution/commit stage and drains them, one per cycle, into the BTB update port (update_valid/pc/target/is_br/is_jal).
- Filters out not-taken conditional branches.
- Coalesces repeated updates to the same PC so that hot loops do not flood the BTB.
- Decouples backend bursts from the BTB's single update port.

Parameters:
- DEPTH, 8, number of queue entries; power of two, minimum 2.
- PC_BITS, 64, width of PC and target fields.
- CNT_BITS, 16, width of the saturating drop and coalesce statistics counters.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low reset
- enq_valid  in  1  resolved control-flow instruction presented
- enq_ready  out  1  queue can accept; a transfer occurs when enq_valid && enq_ready
- enq_pc  in  PC_BITS  instruction PC
- enq_target  in  PC_BITS  resolved target
- enq_is_br  in  1  conditional branch
- enq_is_jal  in  1  direct jump
- enq_taken  in  1  resolved taken
- upd_valid  out  1  update presented to BTB
- upd_ready  in  1  BTB accepts; tie high when the BTB update port has no backpressure
- upd_pc  out  PC_BITS  head entry PC
- upd_target  out  PC_BITS  head entry target
- upd_is_br  out  1  head entry is_br
- upd_is_jal  out  1  head entry is_jal
- count  out  $clog2(DEPTH+1)  current occupancy
- drop_cnt  out  CNT_BITS  saturating count of filtered enqueues (not-taken branches)
- coal_cnt  out  CNT_BITS  saturating count of coalesced enqueues

Behaviour:
- Reset (reset==0 at posedge clock): all entries invalid; head = tail = 0; count = 0; drop_cnt = coal_cnt = 0. While reset is low, enq_ready = 0 and upd_valid = 0. Reset asserted mid-operation discards all contents in the same edge.
- enq_ready = reset && (count != DEPTH). It depends only on state, never on enq_* data. When full, enq_ready = 0 even if a dequeue happens in the same cycle.
- Filter: an accepted enqueue with enq_is_br && !enq_taken is consumed without allocation; drop_cnt increments, saturating at all-ones.
- Coalesce: an accepted, unfiltered enqueue is compared against valid entries, excluding the head entry.
  - On a PC match: overwrite that entry's target, is_br and is_jal in place; no allocation; count unchanged; coal_cnt increments, saturating.
  - At most one entry can match, because the coalescing invariant guarantees non-head entries hold unique PCs.
  - The head is excluded so that upd_* stays stable while upd_valid && !upd_ready.
- Allocate: an unfiltered, non-coalesced enqueue writes to the tail; tail = (tail+1) mod DEPTH; count increments.
- Dequeue: upd_valid = (count != 0). upd_* show the head entry combinationally from storage. A transfer occurs when upd_valid && upd_ready: head advances mod DEPTH; count decrements.
- Simultaneous allocate and dequeue: count unchanged; both pointers advance.
- Empty queue: an allocated entry appears on upd_* the next cycle. Minimum latency is one cycle; there is no bypass.
- Entries remain in FIFO order, except that a coalesced entry keeps its original position.
- upd_* payload is don't-care when upd_valid = 0. The bench checks the payload only when upd_valid = 1.
- Counters and pointers wrap or saturate as stated; occupancy never exceeds DEPTH.

Decomposition:
- Shared package (btb_pkg): typedef btb_update_t {pc, target, is_br, is_jal}; constant BTB_PC_BITS = 64. The same struct is reused by the BTB harness wrapper.
- One natural sub-module: btb_update_match. It is combinational: DEPTH-way PC compare with valid/head masking, producing a one-hot hit vector and a hit flag.
- The storage array and pointer logic remain in btb_update_queue.

Test Plan:
- Basic FIFO: enqueue jal at pc 0x1000 (target 0x2000), then pc 0x1004 (target 0x3000), with upd_ready=1. Required: upd_valid the next cycle showing 0x1000/0x2000, then 0x1004/0x3000; count returns to 0.
- Filter: enqueue is_br=1, taken=0, pc 0x80. Required: upd_valid stays 0, drop_cnt = 1, count = 0.
- Coalesce: upd_ready=0; enqueue pc 0x100 (target 0xA), then 0x200 (target 0xB), then 0x200 (target 0xC). Required: count = 2, coal_cnt = 1. After raising upd_ready: drain order 0x100/0xA, then 0x200/0xC.
- Head protection: upd_ready=0; enqueue pc 0x100 (target 0xA), then pc 0x100 (target 0xD). Required: count = 2; upd_* holds 0x100/0xA and is stable each cycle; the second drained entry is 0x100/0xD.
- Full/backpressure: upd_ready=0; 8 unique enqueues. Required: enq_ready = 0 with count = 8. Then upd_ready=1 and enq_valid held: exactly one dequeue occurs before enq_ready returns to 1; there is no enqueue in the full cycle.
- Reset mid-operation: with 5 entries queued, drive reset=0 for one cycle. Required: count = 0, upd_valid = 0, stats = 0, enq_ready = 0 during reset and 1 afterwards. The next enqueue drains first.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared BTB update types; the update struct is also used by the BTB harness wrapper.
package btb_pkg;

  localparam int BTB_PC_BITS = 64;

  typedef struct packed {
    logic [BTB_PC_BITS-1:0] pc;
    logic [BTB_PC_BITS-1:0] target;
    logic                   is_br;
    logic                   is_jal;
  } btb_update_t;

endpackage

// File: rtl/btb_update_match.sv
// Combinational DEPTH-way PC compare used to coalesce updates into live, non-head entries.
module btb_update_match #(
  parameter int DEPTH   = 8,
  parameter int PC_BITS = 64,
  parameter int PTR_W   = 3
) (
  input  logic [DEPTH*PC_BITS-1:0] pcs,
  input  logic [DEPTH-1:0]         valid,
  input  logic [PTR_W-1:0]         head,
  input  logic [PC_BITS-1:0]       pc,
  output logic [DEPTH-1:0]         hit_vec,
  output logic                     hit
);

  // The head is masked so the entry on upd_* never changes under backpressure.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid[i] && (PTR_W'(i) != head) && (pcs[i*PC_BITS +: PC_BITS] == pc);
    end
    hit = |hit_vec;
  end

endmodule

// File: rtl/btb_update_queue.sv
// Queue between branch resolution and the BTB update port: filters not-taken branches,
// coalesces repeat PCs in place and drains one update per cycle.
module btb_update_queue
  import btb_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PC_BITS  = BTB_PC_BITS,
  parameter int CNT_BITS = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [PC_BITS-1:0]         enq_pc,
  input  logic [PC_BITS-1:0]         enq_target,
  input  logic                       enq_is_br,
  input  logic                       enq_is_jal,
  input  logic                       enq_taken,
  output logic                       upd_valid,
  input  logic                       upd_ready,
  output logic [PC_BITS-1:0]         upd_pc,
  output logic [PC_BITS-1:0]         upd_target,
  output logic                       upd_is_br,
  output logic                       upd_is_jal,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_BITS-1:0]        drop_cnt,
  output logic [CNT_BITS-1:0]        coal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  logic [PC_BITS-1:0] pc_mem_q     [DEPTH];
  logic [PC_BITS-1:0] pc_mem_d     [DEPTH];
  logic [PC_BITS-1:0] target_mem_q [DEPTH];
  logic [PC_BITS-1:0] target_mem_d [DEPTH];
  logic [DEPTH-1:0]   is_br_mem_q, is_br_mem_d;
  logic [DEPTH-1:0]   is_jal_mem_q, is_jal_mem_d;

  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_BITS-1:0] coal_cnt_q, coal_cnt_d;

  logic [DEPTH*PC_BITS-1:0] pcs_flat;
  logic [DEPTH-1:0]         hit_vec;
  logic                     hit;
  logic                     enq_fire, filtered, coalesce, alloc, deq;

  always_comb begin
    pcs_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pcs_flat[i*PC_BITS +: PC_BITS] = pc_mem_q[i];
    end
  end

  btb_update_match #(
    .DEPTH   (DEPTH),
    .PC_BITS (PC_BITS),
    .PTR_W   (PTR_W)
  ) u_match (
    .pcs     (pcs_flat),
    .valid   (vld_q),
    .head    (head_q),
    .pc      (enq_pc),
    .hit_vec (hit_vec),
    .hit     (hit)
  );

  // Ready is a function of occupancy only, so a full queue stalls even when draining.
  assign enq_ready  = reset && (count_q != CNT_W'(DEPTH));
  assign upd_valid  = reset && (count_q != '0);
  assign upd_pc     = pc_mem_q[head_q];
  assign upd_target = target_mem_q[head_q];
  assign upd_is_br  = is_br_mem_q[head_q];
  assign upd_is_jal = is_jal_mem_q[head_q];
  assign count      = count_q;
  assign drop_cnt   = drop_cnt_q;
  assign coal_cnt   = coal_cnt_q;

  always_comb begin
    enq_fire = enq_valid && enq_ready;
    filtered = enq_fire && enq_is_br && !enq_taken;
    coalesce = enq_fire && !filtered && hit;
    alloc    = enq_fire && !filtered && !hit;
    deq      = upd_valid && upd_ready;
  end

  always_comb begin
    vld_d      = vld_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    coal_cnt_d = coal_cnt_q;
    if (filtered) drop_cnt_d = sat_inc(drop_cnt_q);
    if (coalesce) coal_cnt_d = sat_inc(coal_cnt_q);
    if (deq) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
    if (alloc) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PTR_W'(1);
    end
    case ({alloc, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    pc_mem_d     = pc_mem_q;
    target_mem_d = target_mem_q;
    is_br_mem_d  = is_br_mem_q;
    is_jal_mem_d = is_jal_mem_q;
    if (alloc) begin
      pc_mem_d[tail_q]     = enq_pc;
      target_mem_d[tail_q] = enq_target;
      is_br_mem_d[tail_q]  = enq_is_br;
      is_jal_mem_d[tail_q] = enq_is_jal;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (coalesce && hit_vec[i]) begin
        target_mem_d[i] = enq_target;
        is_br_mem_d[i]  = enq_is_br;
        is_jal_mem_d[i] = enq_is_jal;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      coal_cnt_q <= '0;
    end else begin
      vld_q      <= vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      coal_cnt_q <= coal_cnt_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by vld_q and count_q.
  always_ff @(posedge clock) begin
    pc_mem_q     <= pc_mem_d;
    target_mem_q <= target_mem_d;
    is_br_mem_q  <= is_br_mem_d;
    is_jal_mem_q <= is_jal_mem_d;
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: FIFO order, filter, coalesce, head protection, full and reset.
module tb_btb_update_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid, enq_ready;
  logic [63:0] enq_pc, enq_target;
  logic        enq_is_br, enq_is_jal, enq_taken;
  logic        upd_valid, upd_ready;
  logic [63:0] upd_pc, upd_target;
  logic        upd_is_br, upd_is_jal;
  logic [3:0]  count;
  logic [15:0] drop_cnt, coal_cnt;

  int checks = 0;
  int errors = 0;

  btb_update_queue #(.DEPTH(8), .PC_BITS(64), .CNT_BITS(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .enq_pc     (enq_pc),
    .enq_target (enq_target),
    .enq_is_br  (enq_is_br),
    .enq_is_jal (enq_is_jal),
    .enq_taken  (enq_taken),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_is_br  (upd_is_br),
    .upd_is_jal (upd_is_jal),
    .count      (count),
    .drop_cnt   (drop_cnt),
    .coal_cnt   (coal_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [63:0] pc, input logic [63:0] tgt,
                     input logic br, input logic jal, input logic tk);
    enq_valid  = 1'b1;
    enq_pc     = pc;
    enq_target = tgt;
    enq_is_br  = br;
    enq_is_jal = jal;
    enq_taken  = tk;
    step();
    enq_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid got %b exp 0", upd_valid); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL reset_enq_ready got %b exp 0", enq_ready); end
    checks++; if (drop_cnt !== 16'd0 || coal_cnt !== 16'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", drop_cnt, coal_cnt); end
    reset = 1'b1;
    step();
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL post_reset_enq_ready got %b exp 1", enq_ready); end
  endtask

  task automatic test_basic();
    upd_ready = 1'b1;
    enq(64'h1000, 64'h2000, 1'b0, 1'b1, 1'b1);
    checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0 got %b exp 1", upd_valid); end
    checks++; if (upd_pc !== 64'h1000 || upd_target !== 64'h2000) begin errors++; $display("FAIL basic_head0 got %h/%h exp 1000/2000", upd_pc, upd_target); end
    checks++; if (upd_is_jal !== 1'b1 || upd_is_br !== 1'b0) begin errors++; $display("FAIL basic_flags got jal=%b br=%b exp 1/0", upd_is_jal, upd_is_br); end
    enq(64'h1004, 64'h3000, 1'b0, 1'b1, 1'b1);
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 64'h1004 || upd_target !== 64'h3000) begin errors++; $display("FAIL basic_head1 got v=%b %h/%h exp 1 1004/3000", upd_valid, upd_pc, upd_target); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", count); end
    step();
    checks++; if (count !== 4'd0 || upd_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got count=%0d v=%b exp 0/0", count, upd_valid); end
  endtask

  task automatic test_filter();
    upd_ready = 1'b1;
    enq(64'h80, 64'h90, 1'b1, 1'b0, 1'b0);
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL filter_valid got %b exp 0", upd_valid); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL filter_drop got %0d exp 1", drop_cnt); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL filter_count got %0d exp 0", count); end
  endtask

  task automatic test_coalesce();
    upd_ready = 1'b0;
    enq(64'h100, 64'hA, 1'b0, 1'b1, 1'b1);
    enq(64'h200, 64'hB, 1'b0, 1'b1, 1'b1);
    enq(64'h200, 64'hC, 1'b1, 1'b0, 1'b1);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL coal_count got %0d exp 2", count); end
    checks++; if (coal_cnt !== 16'd1) begin errors++; $display("FAIL coal_cnt got %0d exp 1", coal_cnt); end
    upd_ready = 1'b1;
    checks++; if (upd_pc !== 64'h100 || upd_target !== 64'hA) begin errors++; $display("FAIL coal_drain0 got %h/%h exp 100/a", upd_pc, upd_target); end
    step();
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 64'h200 || upd_target !== 64'hC) begin errors++; $display("FAIL coal_drain1 got v=%b %h/%h exp 1 200/c", upd_valid, upd_pc, upd_target); end
    checks++; if (upd_is_br !== 1'b1 || upd_is_jal !== 1'b0) begin errors++; $display("FAIL coal_flags got br=%b jal=%b exp 1/0", upd_is_br, upd_is_jal); end
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL coal_empty got %0d exp 0", count); end
  endtask

  task automatic test_head_protect();
    upd_ready = 1'b0;
    enq(64'h100, 64'hA, 1'b0, 1'b1, 1'b1);
    enq(64'h100, 64'hD, 1'b0, 1'b1, 1'b1);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL head_count got %0d exp 2", count); end
    checks++; if (coal_cnt !== 16'd1) begin errors++; $display("FAIL head_coal got %0d exp 1", coal_cnt); end
    checks++; if (upd_pc !== 64'h100 || upd_target !== 64'hA) begin errors++; $display("FAIL head_hold0 got %h/%h exp 100/a", upd_pc, upd_target); end
    step();
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 64'h100 || upd_target !== 64'hA) begin errors++; $display("FAIL head_hold1 got v=%b %h/%h exp 1 100/a", upd_valid, upd_pc, upd_target); end
    upd_ready = 1'b1;
    step();
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 64'h100 || upd_target !== 64'hD) begin errors++; $display("FAIL head_second got v=%b %h/%h exp 1 100/d", upd_valid, upd_pc, upd_target); end
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL head_empty got %0d exp 0", count); end
  endtask

  task automatic test_full();
    int cyc;
    upd_ready = 1'b0;
    for (int i = 0; i < 8; i++) enq(64'h4000 + 64'(i * 4), 64'(i), 1'b0, 1'b1, 1'b1);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", enq_ready); end
    enq_valid  = 1'b1;
    enq_pc     = 64'h9000;
    enq_target = 64'h77;
    enq_is_br  = 1'b0;
    enq_is_jal = 1'b1;
    enq_taken  = 1'b1;
    upd_ready  = 1'b1;
    #1;
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready_while_deq got %b exp 0", enq_ready); end
    step();
    checks++; if (count !== 4'd7 || enq_ready !== 1'b1) begin errors++; $display("FAIL full_one_deq got count=%0d rdy=%b exp 7/1", count, enq_ready); end
    upd_ready = 1'b0;
    step();
    enq_valid = 1'b0;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_refill got %0d exp 8", count); end
    checks++; if (upd_pc !== 64'h4004 || upd_target !== 64'h1) begin errors++; $display("FAIL full_head got %h/%h exp 4004/1", upd_pc, upd_target); end
    upd_ready = 1'b1;
    cyc = 0;
    while (count != 4'd1 && cyc < 20) begin
      step();
      cyc++;
    end
    checks++; if (upd_pc !== 64'h9000 || upd_target !== 64'h77) begin errors++; $display("FAIL full_tail got %h/%h exp 9000/77", upd_pc, upd_target); end
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid();
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) enq(64'h6000 + 64'(i * 4), 64'(i + 16), 1'b0, 1'b1, 1'b1);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_count_pre got %0d exp 5", count); end
    reset = 1'b0;
    step();
    checks++; if (count !== 4'd0 || upd_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_state got count=%0d v=%b exp 0/0", count, upd_valid); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b exp 0", enq_ready); end
    checks++; if (drop_cnt !== 16'd0 || coal_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_stats got %0d/%0d exp 0/0", drop_cnt, coal_cnt); end
    reset = 1'b1;
    #1;
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready got %b exp 1", enq_ready); end
    enq(64'hABC0, 64'h55, 1'b0, 1'b1, 1'b1);
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 64'hABC0 || upd_target !== 64'h55) begin errors++; $display("FAIL mid_first got v=%b %h/%h exp 1 abc0/55", upd_valid, upd_pc, upd_target); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL mid_count_post got %0d exp 1", count); end
  endtask

  initial begin
    reset      = 1'b0;
    enq_valid  = 1'b0;
    enq_pc     = '0;
    enq_target = '0;
    enq_is_br  = 1'b0;
    enq_is_jal = 1'b0;
    enq_taken  = 1'b0;
    upd_ready  = 1'b0;
    test_reset();
    test_basic();
    test_filter();
    test_coalesce();
    test_head_protect();
    test_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
